// File: rtl/trgt_edge_pool.sv
// Mission-clock edge collector: synchronises raw mission clocks, captures per-clock data on rising edges,
// queues them in a FWFT pool and requests a clock freeze while work is outstanding. Optional tag: TRGT_EDGE_POOL_SEQ_EN.
module trgt_edge_pool #(
    parameter int N_CLOCKS   = 4,
    parameter int DATA_W     = 9,
    parameter int POOL_DEPTH = 8
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [N_CLOCKS-1:0]             mclk_i,
    input  logic [N_CLOCKS*DATA_W-1:0]      data_i,
    output logic [N_CLOCKS-1:0]             freeze_clk_o,
    output logic                            ent_valid_o,
    input  logic                            ent_ready_i,
    output logic [$clog2(N_CLOCKS)-1:0]     ent_clk_id_o,
    output logic [DATA_W-1:0]               ent_data_o,
    output logic [$clog2(POOL_DEPTH+1)-1:0] pool_level_o,
    output logic                            overflow_o,
    output logic                            busy_o
`ifdef TRGT_EDGE_POOL_SEQ_EN
    ,
    output logic [7:0]                      ent_seq_o
`endif
);

    localparam int IDW = $clog2(N_CLOCKS);
    localparam int AW  = $clog2(POOL_DEPTH);
    localparam int LW  = $clog2(POOL_DEPTH+1);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRAIN} state_t;

    logic [N_CLOCKS-1:0] sync1_q, sync2_q, prev_q, rise;
    logic [N_CLOCKS-1:0] pending_q, pending_d, clr_mask, hold_we;
    logic [DATA_W-1:0]   hold_q [N_CLOCKS];
    logic [IDW-1:0]      sel_id;
    logic                sel_found, push, pop, full, empty, drop;
    logic [AW:0]         wr_q, rd_q, level;
    logic [IDW-1:0]      mem_id   [POOL_DEPTH];
    logic [DATA_W-1:0]   mem_data [POOL_DEPTH];
    state_t              state_q, state_d;
    logic                busy_q;
    logic [N_CLOCKS-1:0] freeze_q;
    logic                overflow_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= mclk_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise  = sync2_q & ~prev_q;
    assign level = wr_q - rd_q;
    assign empty = (wr_q == rd_q);
    assign full  = (level == (AW+1)'(POOL_DEPTH));
    assign push  = sel_found && !full;
    assign pop   = ent_valid_o && ent_ready_i;

    // Lowest-index pending clock wins the single push slot
    always_comb begin
        sel_id    = '0;
        sel_found = 1'b0;
        clr_mask  = '0;
        for (int i = 0; i < N_CLOCKS; i++) begin
            if (pending_q[i] && !sel_found) begin
                sel_found = 1'b1;
                sel_id    = IDW'(i);
            end
        end
        if (push) clr_mask[sel_id] = 1'b1;
    end

    // A rise on a clock whose pending entry survives this cycle is dropped; a rise coinciding with its push wins
    always_comb begin
        hold_we   = rise & ~(pending_q & ~clr_mask);
        pending_d = rise | (pending_q & ~clr_mask);
        drop      = |(rise & pending_q & ~clr_mask);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q  <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < N_CLOCKS; i++) hold_q[i] <= '0;
        end else begin
            pending_q <= pending_d;
            if (drop) overflow_q <= 1'b1;
            for (int i = 0; i < N_CLOCKS; i++)
                if (hold_we[i]) hold_q[i] <= data_i[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_id[wr_q[AW-1:0]]   <= sel_id;
            mem_data[wr_q[AW-1:0]] <= hold_q[sel_id];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (|pending_q) state_d = ST_LOAD;
            ST_LOAD:  if (pending_q == '0) state_d = empty ? ST_IDLE : ST_DRAIN;
            ST_DRAIN: begin
                if (|pending_q)  state_d = ST_LOAD;
                else if (empty)  state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // busy and freeze share the registered next-state decision so they move together
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            freeze_q <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= (state_d != ST_IDLE);
            freeze_q <= {N_CLOCKS{state_d != ST_IDLE}};
        end
    end

    assign ent_valid_o  = !empty;
    assign ent_clk_id_o = ent_valid_o ? mem_id[rd_q[AW-1:0]]   : '0;
    assign ent_data_o   = ent_valid_o ? mem_data[rd_q[AW-1:0]] : '0;
    assign pool_level_o = LW'(level);
    assign overflow_o   = overflow_q;
    assign busy_o       = busy_q;
    assign freeze_clk_o = freeze_q;

`ifdef TRGT_EDGE_POOL_SEQ_EN
    logic [7:0] seq_q;
    logic [7:0] mem_seq [POOL_DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)   seq_q <= '0;
        else if (push) seq_q <= seq_q + 8'd1;
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_seq[wr_q[AW-1:0]] <= seq_q;
    end

    assign ent_seq_o = ent_valid_o ? mem_seq[rd_q[AW-1:0]] : 8'd0;
`endif

endmodule

// File: tb/tb_trgt_edge_pool.sv
// Self-checking bench for trgt_edge_pool: table-driven single-edge vectors plus
// directed sequences for burst ordering, pool saturation, overflow, async reset and sequence tags.
module tb_trgt_edge_pool;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [3:0]  mclk_i;
    logic [35:0] data_i;
    logic [3:0]  freeze_clk_o;
    logic        ent_valid_o;
    logic        ent_ready_i;
    logic [1:0]  ent_clk_id_o;
    logic [8:0]  ent_data_o;
    logic [3:0]  pool_level_o;
    logic        overflow_o;
    logic        busy_o;
`ifdef TRGT_EDGE_POOL_SEQ_EN
    logic [7:0]  ent_seq_o;
`endif

    int checks = 0;
    int errors = 0;

    trgt_edge_pool #(.N_CLOCKS(4), .DATA_W(9), .POOL_DEPTH(8)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .mclk_i       (mclk_i),
        .data_i       (data_i),
        .freeze_clk_o (freeze_clk_o),
        .ent_valid_o  (ent_valid_o),
        .ent_ready_i  (ent_ready_i),
        .ent_clk_id_o (ent_clk_id_o),
        .ent_data_o   (ent_data_o),
        .pool_level_o (pool_level_o),
        .overflow_o   (overflow_o),
        .busy_o       (busy_o)
`ifdef TRGT_EDGE_POOL_SEQ_EN
        ,
        .ent_seq_o    (ent_seq_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] clk_id;
        logic [8:0] data;
        logic [1:0] exp_id;
        logic [8:0] exp_data;
    } vec_t;

    vec_t vecs [4];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic applyStimulus(input logic [3:0] mask, input logic [35:0] data);
        data_i = data;
        mclk_i = mask;
        repeat (3) tick();
        mclk_i = 4'h0;
        repeat (3) tick();
    endtask

    task automatic waitValid(input int max_cycles, output bit seen);
        seen = 1'b0;
        for (int c = 0; c < max_cycles && !seen; c++) begin
            tick();
            if (ent_valid_o) seen = 1'b1;
        end
    endtask

`ifdef TRGT_EDGE_POOL_SEQ_EN
    bit seq_mon_en = 1'b0;
    int seq_seen   = 0;

    always @(negedge clk) begin
        if (seq_mon_en) begin
            if (ent_valid_o) begin
                checkOutput("seq_tag", 32'(ent_seq_o), 32'(seq_seen % 256));
                if (ent_ready_i) seq_seen++;
            end else begin
                checkOutput("seq_idle_zero", 32'(ent_seq_o), 32'h0);
            end
        end
    end
`endif

    initial begin
        logic [35:0] dv;
        bit          seen;

        vecs[0] = '{clk_id: 2'd2, data: 9'h0A5, exp_id: 2'd2, exp_data: 9'h0A5};
        vecs[1] = '{clk_id: 2'd0, data: 9'h1FF, exp_id: 2'd0, exp_data: 9'h1FF};
        vecs[2] = '{clk_id: 2'd3, data: 9'h100, exp_id: 2'd3, exp_data: 9'h100};
        vecs[3] = '{clk_id: 2'd1, data: 9'h001, exp_id: 2'd1, exp_data: 9'h001};

        rst_ni      = 1'b0;
        mclk_i      = 4'h0;
        data_i      = '0;
        ent_ready_i = 1'b0;
        tick();
        checkOutput("rst_valid",    32'(ent_valid_o),  32'h0);
        checkOutput("rst_level",    32'(pool_level_o), 32'h0);
        checkOutput("rst_freeze",   32'(freeze_clk_o), 32'h0);
        checkOutput("rst_busy",     32'(busy_o),       32'h0);
        checkOutput("rst_overflow", 32'(overflow_o),   32'h0);
        checkOutput("rst_id",       32'(ent_clk_id_o), 32'h0);
        checkOutput("rst_data",     32'(ent_data_o),   32'h0);
        rst_ni = 1'b1;
        tick();

        // Single edges with ready held high: exact latency, one-cycle valid, freeze window
        ent_ready_i = 1'b1;
        for (int v = 0; v < 4; v++) begin
            for (int j = 0; j < 4; j++)
                dv[j*9 +: 9] = (j == int'(vecs[v].clk_id)) ? vecs[v].data : (9'h155 ^ 9'(j));
            data_i = dv;
            mclk_i = 4'h1 << vecs[v].clk_id;
            repeat (3) tick();
            checkOutput("vec_valid_early", 32'(ent_valid_o), 32'h0);
            mclk_i = 4'h0;
            tick();
            checkOutput("vec_valid",  32'(ent_valid_o),  32'h1);
            checkOutput("vec_id",     32'(ent_clk_id_o), 32'(vecs[v].exp_id));
            checkOutput("vec_data",   32'(ent_data_o),   32'(vecs[v].exp_data));
            checkOutput("vec_level",  32'(pool_level_o), 32'h1);
            checkOutput("vec_freeze", 32'(freeze_clk_o), 32'hF);
            checkOutput("vec_busy",   32'(busy_o),       32'h1);
            tick();
            checkOutput("vec_valid_gone", 32'(ent_valid_o),  32'h0);
            checkOutput("vec_level_zero", 32'(pool_level_o), 32'h0);
            checkOutput("vec_freeze_hold", 32'(freeze_clk_o), 32'hF);
            tick();
            checkOutput("vec_freeze_off", 32'(freeze_clk_o), 32'h0);
            checkOutput("vec_busy_off",   32'(busy_o),       32'h0);
            repeat (2) tick();
        end

        // Simultaneous rises on all clocks: one push per cycle, lowest index first
        ent_ready_i = 1'b0;
        data_i = {9'h034, 9'h1C3, 9'h0B2, 9'h101};
        mclk_i = 4'hF;
        repeat (3) tick();
        mclk_i = 4'h0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checkOutput("burst_level", 32'(pool_level_o), 32'(k));
        end
        ent_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checkOutput("burst_valid", 32'(ent_valid_o),  32'h1);
            checkOutput("burst_id",    32'(ent_clk_id_o), 32'(k));
            checkOutput("burst_data",  32'(ent_data_o),   32'(dv_slice(36'({9'h034, 9'h1C3, 9'h0B2, 9'h101}), k)));
            tick();
        end
        checkOutput("burst_empty", 32'(ent_valid_o), 32'h0);
        repeat (3) tick();

        // Saturation: 8 entries fill the pool, the ninth waits in pending, a second rise on it overflows
        doReset();
        ent_ready_i = 1'b0;
        for (int k = 0; k < 8; k++) applyStimulus(4'h1, {27'h0, 9'(9'h010 + 9'(k))});
        checkOutput("sat_level8", 32'(pool_level_o), 32'h8);
        applyStimulus(4'h2, {18'h0, 9'h0C1, 9'h000});
        checkOutput("sat_level_hold", 32'(pool_level_o), 32'h8);
        checkOutput("sat_no_overflow", 32'(overflow_o),  32'h0);
        applyStimulus(4'h2, {18'h0, 9'h0C2, 9'h000});
        checkOutput("ovf_set", 32'(overflow_o), 32'h1);
        checkOutput("ovf_head_id",   32'(ent_clk_id_o), 32'h0);
        checkOutput("ovf_head_data", 32'(ent_data_o),   32'h010);
        ent_ready_i = 1'b1;
        tick();
        ent_ready_i = 1'b0;
        checkOutput("sat_after_pop", 32'(pool_level_o), 32'h7);
        tick();
        checkOutput("sat_refill", 32'(pool_level_o), 32'h8);
        ent_ready_i = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            checkOutput("sat_valid", 32'(ent_valid_o),  32'h1);
            checkOutput("sat_id",    32'(ent_clk_id_o), (k < 8) ? 32'h0 : 32'h1);
            checkOutput("sat_data",  32'(ent_data_o),   (k < 8) ? 32'(9'h010 + 9'(k)) : 32'h0C1);
            tick();
        end
        checkOutput("sat_drained",  32'(ent_valid_o), 32'h0);
        checkOutput("ovf_sticky",   32'(overflow_o),  32'h1);
        repeat (3) tick();
        checkOutput("ovf_sticky_idle", 32'(overflow_o), 32'h1);

        // Asynchronous reset with three queued entries and freeze asserted
        doReset();
        ent_ready_i = 1'b0;
        applyStimulus(4'h7, {9'h000, 9'h0E2, 9'h0E1, 9'h0E0});
        checkOutput("mid_level3", 32'(pool_level_o), 32'h3);
        checkOutput("mid_freeze", 32'(freeze_clk_o), 32'hF);
        #2 rst_ni = 1'b0;
        #1;
        checkOutput("arst_valid",    32'(ent_valid_o),  32'h0);
        checkOutput("arst_level",    32'(pool_level_o), 32'h0);
        checkOutput("arst_freeze",   32'(freeze_clk_o), 32'h0);
        checkOutput("arst_busy",     32'(busy_o),       32'h0);
        checkOutput("arst_overflow", 32'(overflow_o),   32'h0);
        checkOutput("arst_id",       32'(ent_clk_id_o), 32'h0);
        checkOutput("arst_data",     32'(ent_data_o),   32'h0);
        tick();
        rst_ni = 1'b1;
        tick();
        ent_ready_i = 1'b1;
        data_i = {9'h0AA, 27'h0};
        mclk_i = 4'h8;
        waitValid(10, seen);
        checkOutput("post_rst_seen", 32'(seen), 32'h1);
        checkOutput("post_rst_id",   32'(ent_clk_id_o), 32'h3);
        checkOutput("post_rst_data", 32'(ent_data_o),   32'h0AA);
`ifdef TRGT_EDGE_POOL_SEQ_EN
        checkOutput("post_rst_seq",  32'(ent_seq_o),    32'h0);
`endif
        mclk_i = 4'h0;
        repeat (4) tick();

`ifdef TRGT_EDGE_POOL_SEQ_EN
        // 257 pushes: tags run 0..255 then wrap to 0
        doReset();
        ent_ready_i = 1'b1;
        seq_mon_en  = 1'b1;
        for (int k = 0; k < 257; k++) applyStimulus(4'h1, {27'h0, 9'(k)});
        seq_mon_en  = 1'b0;
        checkOutput("seq_count", 32'(seq_seen), 32'd257);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    function automatic logic [8:0] dv_slice(input logic [35:0] v, input int idx);
        return v[idx*9 +: 9];
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/trgt_edge_pool.md
# trgt_edge_pool

Target-side mission-clock edge collector and transaction pool that feeds the fringe put engine. It samples up to N_CLOCKS mission clocks on the utility clock and captures the per-clock data word on each rising edge. Captured entries are queued in arrival order and presented one at a time over a valid/ready handshake. It also drives the mission-clock freeze while exchange work is outstanding.

## Interface
Parameters:
- N_CLOCKS, 4, number of mission clocks (index = clock id; 0..3 map to clk6, clk7, clk8, clk11)
- DATA_W, 9, width of the per-clock data word ({valid, o_data} for clock 3)
- POOL_DEPTH, 8, FIFO entries, power of two, ≥2

Ports:
- clk_i  in  1  utility clock; all logic on posedge
- rst_ni  in  1  asynchronous active-low reset
- mclk_i  in  N_CLOCKS  raw mission clocks, asynchronous to clk_i
- data_i  in  N_CLOCKS*DATA_W  per-clock data; slice i = data_i[i*DATA_W +: DATA_W]
- freeze_clk_o  out  N_CLOCKS  mission-clock block request, registered
- ent_valid_o  out  1  pool head valid
- ent_ready_i  in  1  put engine accepts head
- ent_clk_id_o  out  $clog2(N_CLOCKS)  clock id of head entry
- ent_data_o  out  DATA_W  data of head entry
- pool_level_o  out  $clog2(POOL_DEPTH+1)  entries in pool, 0..POOL_DEPTH
- overflow_o  out  1  sticky drop flag
- busy_o  out  1  FSM not in IDLE

## Operation
- Each mclk_i bit passes through a 2-FF synchronizer and a third flop. Rise = sync & ~prev.
- On a rise of clock i: pending[i] is set and hold[i] captures data slice i in that cycle.
- A rise on clock i while pending[i] is already set is dropped. The older data is kept and overflow_o is set.
- Push: each cycle, the lowest-index set pending bit is written to the FIFO as {i, hold[i]} and its pending bit is cleared, provided the FIFO is not full. A push is blocked when the FIFO is full, even if a pop happens in the same cycle.
- Pending clear and a new rise on the same clock in the same cycle: the new rise wins. pending stays 1 and hold takes the new data.
- Pop: on ent_valid_o & ent_ready_i at posedge. The head is shown first-word-fall-through from registered storage.
- FSM:
  - IDLE: pending==0 and the FIFO is empty. Moves to LOAD when any pending bit is set.
  - LOAD: pending≠0. Moves to DRAIN when pending==0 and the FIFO is non-empty. Moves to IDLE when pending==0 and the FIFO is empty.
  - DRAIN: moves to LOAD on any pending bit. Moves to IDLE when the FIFO is empty and pending==0.
- freeze_clk_o: all bits are driven to 1 in the cycle after the FSM next state is not IDLE. All bits are driven to 0 in the cycle after it returns to IDLE.
- overflow_o is cleared only by reset.
- Reset values: freeze_clk_o=0, ent_valid_o=0, ent_clk_id_o=0, ent_data_o=0, pool_level_o=0, overflow_o=0, busy_o=0. Pending, hold and the FIFO pointers are cleared.
- Reset asserted mid-operation discards all queued and pending entries immediately. No output glitches high.

## Timing
- Mission rise sampled at posedge t → rise detected at t+2 (pending, hold written) → push at t+3 at the earliest → ent_valid_o=1 from t+4.
- ent_valid_o holds, with ent_clk_id_o and ent_data_o stable, until accepted. The next head appears in the cycle after the pop.
- Throughput: one push and one pop per cycle.
- Simultaneous rises on k clocks drain into the FIFO over k cycles, lowest index first.
- Pointers wrap modulo POOL_DEPTH. An extra wrap bit distinguishes full from empty.
- freeze_clk_o lags busy_o by 0 cycles. Both come from the same registered next state.

## Configuration
- TRGT_EDGE_POOL_SEQ_EN defined: adds output ent_seq_o [7:0], an 8-bit tag stored with each entry.
  - The tag starts at 0 after reset and increments per push, wrapping 255→0.
  - ent_seq_o is 0 while ent_valid_o=0.
- Undefined: the port and its storage are absent. All other behaviour is identical.

## Test plan
- Single rise on mclk_i[2] with slice 2 = 9'h0A5 and ent_ready_i=1 → ent_valid_o for 1 cycle at t+4 with id=2 and data=9'h0A5. freeze_clk_o=4'hF while busy, 0 afterwards. pool_level_o returns to 0.
- Simultaneous rises on all 4 clocks with ent_ready_i=0 → pool_level_o steps 1,2,3,4. Raising ready then pops ids 0,1,2,3 in order on consecutive cycles.
- ent_ready_i=0 and 9 distinct rise events with POOL_DEPTH=8 → level saturates at 8. The ninth entry stays pending and is pushed after the first pop. overflow_o stays 0.
- Two rises on clock 1 with the FIFO full (pending[1] already set) → the second rise is dropped and overflow_o=1 sticky. The delivered data is from the first rise.
- Assert rst_ni low while 3 entries are queued and freeze is high → all outputs are 0 asynchronously. After release, a new rise is delivered normally (with SEQ_EN: ent_seq_o=0).
- With TRGT_EDGE_POOL_SEQ_EN: 257 pushes → tags run 0..255 then 0.
